// File: rtl/pid_regulator.sv
// pid_regulator
//   Strobe-driven PID voltage regulator. Each accepted ADC sample runs a
//   fixed six-cycle pass through one shared multiplier:
//     IDLE -> ERR -> MUL_P -> MUL_I -> MUL_D -> SAT -> IDLE
//   The pass computes the error, the derivative and the clamped integrator
//   (with anti-windup). It accumulates k_p*e + k_i*I + k_d*d, then scales the
//   result by 2^-FRAC_BITS and saturates it into an unsigned duty word.
//
// Ports
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   sample_valid         one-cycle strobe, cur_vd carries a new sample
//   cur_vd, target_v     measured voltage and set point (unsigned)
//   coef_wr/sel/data     shadow gain write (sel 0=k_p 1=k_i 2=k_d 3=clear state)
//   duty_out, duty_valid latest duty word, one-cycle update pulse
//   busy                 computation in progress
//   sat_hi, sat_lo       last result clamped high / low
//   overrun              sticky, a sample arrived while busy and was dropped
//   pwm_out              gate drive
//
// Build option
//   PID_REGULATOR_PWM_EN  builds the PWM generator. When the macro is
//                         undefined, pwm_out is tied low.

module pid_regulator #(
    parameter int ADC_WIDTH  = 8,
    parameter int COEF_WIDTH = 8,
    parameter int FRAC_BITS  = 4,
    parameter int INT_WIDTH  = 16,
    parameter int OUT_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_valid,
    input  logic [ADC_WIDTH-1:0]  cur_vd,
    input  logic [ADC_WIDTH-1:0]  target_v,
    input  logic                  coef_wr,
    input  logic [1:0]            coef_sel,
    input  logic [COEF_WIDTH-1:0] coef_data,
    output logic [OUT_WIDTH-1:0]  duty_out,
    output logic                  duty_valid,
    output logic                  busy,
    output logic                  sat_hi,
    output logic                  sat_lo,
    output logic                  overrun,
    output logic                  pwm_out
);

    localparam int E_W    = ADC_WIDTH + 1;                      // error
    localparam int D_W    = ADC_WIDTH + 2;                      // derivative
    localparam int MB_W   = (INT_WIDTH > D_W) ? INT_WIDTH : D_W;
    localparam int PROD_W = COEF_WIDTH + 1 + MB_W;              // signed product
    localparam int ACC_W  = PROD_W + 2;                         // three summed products
    localparam int SUM_W  = INT_WIDTH + 1;                      // I + e before clamp

    typedef enum logic [2:0] {
        S_IDLE, S_ERR, S_MUL_P, S_MUL_I, S_MUL_D, S_SAT
    } state_t;

    state_t state, state_nxt;

    logic [ADC_WIDTH-1:0]  cur_q, tgt_q;
    logic [COEF_WIDTH-1:0] kp_sh, ki_sh, kd_sh;
    logic [COEF_WIDTH-1:0] kp_sh_nxt, ki_sh_nxt, kd_sh_nxt;
    logic [COEF_WIDTH-1:0] kp, ki, kd;
    logic                  clr_pend;
    logic [E_W-1:0]        e_q, e_prev, e_calc;
    logic [D_W-1:0]        d_q, d_calc;
    logic [INT_WIDTH-1:0]  integ, i_clamped;
    logic [SUM_W-1:0]      i_sum;
    logic                  i_hold;
    logic signed [PROD_W-1:0] op_a, op_b, prod;
    logic signed [ACC_W-1:0]  acc, prod_ext, u;
    logic                  accept, clr_now, clr_wr;
    logic                  u_neg, u_big;

    assign accept  = (state == S_IDLE) && sample_valid;
    assign clr_wr  = coef_wr && (coef_sel == 2'd3);
    assign clr_now = clr_pend || clr_wr;
    assign busy    = (state != S_IDLE);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            S_IDLE:  if (sample_valid) state_nxt = S_ERR;
            S_ERR:   state_nxt = S_MUL_P;
            S_MUL_P: state_nxt = S_MUL_I;
            S_MUL_I: state_nxt = S_MUL_D;
            S_MUL_D: state_nxt = S_SAT;
            S_SAT:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- shadow gain write ----------------
    // The next-shadow value is what an accept copies. A write in the same
    // cycle as an accept therefore applies to that sample.
    always_comb begin
        kp_sh_nxt = kp_sh;
        ki_sh_nxt = ki_sh;
        kd_sh_nxt = kd_sh;
        if (coef_wr) begin
            case (coef_sel)
                2'd0:    kp_sh_nxt = coef_data;
                2'd1:    ki_sh_nxt = coef_data;
                2'd2:    kd_sh_nxt = coef_data;
                default: ;
            endcase
        end
    end

    // ---------------- error path ----------------
    assign e_calc = {1'b0, tgt_q} - {1'b0, cur_q};
    assign d_calc = {e_calc[E_W-1], e_calc} - {e_prev[E_W-1], e_prev};
    assign i_sum  = {integ[INT_WIDTH-1], integ}
                  + {{(SUM_W-E_W){e_calc[E_W-1]}}, e_calc};

    // When the two top bits disagree, the sum has left the INT_WIDTH range.
    always_comb begin
        i_clamped = i_sum[INT_WIDTH-1:0];
        if (i_sum[SUM_W-1] != i_sum[SUM_W-2]) begin
            i_clamped = i_sum[SUM_W-1] ? {1'b1, {(INT_WIDTH-1){1'b0}}}
                                       : {1'b0, {(INT_WIDTH-1){1'b1}}};
        end
    end

    // Anti-windup uses the saturation flags of the previous result.
    assign i_hold = (sat_hi && !e_calc[E_W-1] && (e_calc != '0))
                 || (sat_lo &&  e_calc[E_W-1]);

    // ---------------- shared multiplier ----------------
    // Gains are zero-extended. Signed operands are sign-extended to product width.
    always_comb begin
        op_a = '0;
        op_b = '0;
        case (state)
            S_MUL_P: begin
                op_a = {{(PROD_W-COEF_WIDTH){1'b0}}, kp};
                op_b = {{(PROD_W-E_W){e_q[E_W-1]}}, e_q};
            end
            S_MUL_I: begin
                op_a = {{(PROD_W-COEF_WIDTH){1'b0}}, ki};
                op_b = {{(PROD_W-INT_WIDTH){integ[INT_WIDTH-1]}}, integ};
            end
            S_MUL_D: begin
                op_a = {{(PROD_W-COEF_WIDTH){1'b0}}, kd};
                op_b = {{(PROD_W-D_W){d_q[D_W-1]}}, d_q};
            end
            default: ;
        endcase
    end

    assign prod     = op_a * op_b;
    assign prod_ext = {{2{prod[PROD_W-1]}}, prod};

    // ---------------- scaling and saturation ----------------
    assign u     = acc >>> FRAC_BITS;
    assign u_neg = u[ACC_W-1];
    assign u_big = !u_neg && (|u[ACC_W-2:OUT_WIDTH]);

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_q      <= '0;
            tgt_q      <= '0;
            kp_sh      <= '0;
            ki_sh      <= '0;
            kd_sh      <= '0;
            kp         <= '0;
            ki         <= '0;
            kd         <= '0;
            clr_pend   <= 1'b0;
            e_q        <= '0;
            d_q        <= '0;
            e_prev     <= '0;
            integ      <= '0;
            acc        <= '0;
            duty_out   <= '0;
            duty_valid <= 1'b0;
            sat_hi     <= 1'b0;
            sat_lo     <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            duty_valid <= 1'b0;
            kp_sh      <= kp_sh_nxt;
            ki_sh      <= ki_sh_nxt;
            kd_sh      <= kd_sh_nxt;

            // A sample that arrives mid-computation is dropped.
            if (busy && sample_valid) begin
                overrun <= 1'b1;
            end

            if (accept) begin
                cur_q    <= cur_vd;
                tgt_q    <= target_v;
                kp       <= kp_sh_nxt;
                ki       <= ki_sh_nxt;
                kd       <= kd_sh_nxt;
                clr_pend <= 1'b0;
                if (clr_now) begin
                    integ   <= '0;
                    e_prev  <= '0;
                    overrun <= 1'b0;
                end
            end else if (clr_wr) begin
                clr_pend <= 1'b1;
            end

            case (state)
                S_ERR: begin
                    e_q    <= e_calc;
                    d_q    <= d_calc;
                    e_prev <= e_calc;
                    acc    <= '0;
                    if (!i_hold) begin
                        integ <= i_clamped;
                    end
                end
                S_MUL_P, S_MUL_I, S_MUL_D: begin
                    acc <= acc + prod_ext;
                end
                S_SAT: begin
                    duty_valid <= 1'b1;
                    sat_lo     <= u_neg;
                    sat_hi     <= u_big;
                    if (u_neg) begin
                        duty_out <= '0;
                    end else if (u_big) begin
                        duty_out <= '1;
                    end else begin
                        duty_out <= u[OUT_WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- PWM generator ----------------
`ifdef PID_REGULATOR_PWM_EN
    // The counter runs 0 .. 2^OUT_WIDTH-2, so a full-scale duty is constant high.
    localparam logic [OUT_WIDTH-1:0] CNT_LAST = {{(OUT_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [OUT_WIDTH-1:0] CNT_ONE  = 1;

    logic [OUT_WIDTH-1:0] cnt, duty_act;

    // duty_act only reloads at the wrap, so a period is never cut short.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            duty_act <= '0;
            pwm_out  <= 1'b0;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt      <= '0;
                duty_act <= duty_out;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
            pwm_out <= (cnt < duty_act);
        end
    end
`else
    assign pwm_out = 1'b0;
`endif

endmodule
